// File: rtl/ud_counter_hex7_if.sv
// Board-side bundle for the up/down hex counter: direction switch in,
// count value and 7-segment pattern out.
interface ud_counter_hex7_if;
    logic       x;
    logic [3:0] out;
    logic [6:0] display;

    // Driver side: board switch logic, display consumer.
    modport master (
        output x,
        input  out,
        input  display
    );

    // Counter side.
    modport slave (
        input  x,
        output out,
        output display
    );
endinterface

// File: rtl/ud_counter_hex7.sv
// 4-bit synchronous up/down counter with a hexadecimal 7-segment decoder.
// Optional feature macro: UD_COUNTER_BCD_EN (decimal 0..9 counting when defined).
// SEG_ACTIVE_LOW=1 inverts every display bit for common-anode panels.
module ud_counter_hex7 #(
    parameter bit SEG_ACTIVE_LOW = 1'b0
) (
    input logic             cp,
    input logic             reset,
    ud_counter_hex7_if.slave bus
);

    logic [3:0] count_q;
    logic [3:0] count_d;
    logic [6:0] seg;

    // Next count: +1 when x is high, -1 when low, wrapping at the range ends.
    always_comb begin
        count_d = count_q;
`ifdef UD_COUNTER_BCD_EN
        // Out-of-range values (A..F) recover to the wrap target of the direction.
        if (bus.x) begin
            count_d = (count_q >= 4'd9) ? 4'd0 : count_q + 4'd1;
        end else begin
            count_d = (count_q == 4'd0 || count_q > 4'd9) ? 4'd9 : count_q - 4'd1;
        end
`else
        if (bus.x) begin
            count_d = count_q + 4'd1;
        end else begin
            count_d = count_q - 4'd1;
        end
`endif
    end

    // Count register; synchronous active-low reset overrides direction.
    always_ff @(posedge cp) begin
        if (!reset) begin
            count_q <= 4'h0;
        end else begin
            count_q <= count_d;
        end
    end

    // Hex decoder, segments ordered {a,b,c,d,e,f,g}, active-high before polarity.
    always_comb begin
        seg = 7'b0000000;
        case (count_q)
            4'h0:    seg = 7'b1111110;
            4'h1:    seg = 7'b0110000;
            4'h2:    seg = 7'b1101101;
            4'h3:    seg = 7'b1111001;
            4'h4:    seg = 7'b0110011;
            4'h5:    seg = 7'b1011011;
            4'h6:    seg = 7'b1011111;
            4'h7:    seg = 7'b1110000;
            4'h8:    seg = 7'b1111111;
            4'h9:    seg = 7'b1111011;
            4'hA:    seg = 7'b1110111;
            4'hB:    seg = 7'b0011111;
            4'hC:    seg = 7'b1001110;
            4'hD:    seg = 7'b0111101;
            4'hE:    seg = 7'b1001111;
            4'hF:    seg = 7'b1000111;
            // Unknown count blanks the digit.
            default: seg = 7'b0000000;
        endcase
    end

    assign bus.out     = count_q;
    assign bus.display = SEG_ACTIVE_LOW ? ~seg : seg;

endmodule

// File: tb/tb_ud_counter_hex7.sv
// Self-checking bench for ud_counter_hex7: an active-high and an active-low
// instance share the same stimulus and are compared against a modular
// arithmetic reference model plus the segment table.
module tb_ud_counter_hex7;

`ifdef UD_COUNTER_BCD_EN
    localparam int Modulus = 10;
`else
    localparam int Modulus = 16;
`endif

    logic cp = 1'b0;
    logic reset;

    ud_counter_hex7_if bus_hi ();
    ud_counter_hex7_if bus_lo ();

    ud_counter_hex7 #(.SEG_ACTIVE_LOW(1'b0)) u_dut_hi (
        .cp    (cp),
        .reset (reset),
        .bus   (bus_hi)
    );

    ud_counter_hex7 #(.SEG_ACTIVE_LOW(1'b1)) u_dut_lo (
        .cp    (cp),
        .reset (reset),
        .bus   (bus_lo)
    );

    always #5 cp = ~cp;

    int n_checks = 0;
    int n_pass   = 0;
    int model    = 0;

    logic [6:0] seg_tab [16];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Drive one cycle's inputs away from the edge, advance the model on the
    // edge, then compare both instances shortly after it.
    task automatic step(input logic xv, input logic rv);
        @(negedge cp);
        bus_hi.x = xv;
        bus_lo.x = xv;
        reset    = rv;
        @(posedge cp);
        if (!rv) begin
            model = 0;
        end else if (xv) begin
            model = (model + 1) % Modulus;
        end else begin
            model = (model + Modulus - 1) % Modulus;
        end
        #1;
        check("out_hi", {28'd0, bus_hi.out}, model);
        check("disp_hi", {25'd0, bus_hi.display}, {25'd0, seg_tab[model]});
        check("out_lo", {28'd0, bus_lo.out}, model);
        check("disp_lo", {25'd0, bus_lo.display}, {25'd0, ~seg_tab[model]});
    endtask

    initial begin
        seg_tab = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
                    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};
        bus_hi.x = 1'b1;
        bus_lo.x = 1'b1;
        reset    = 1'b0;

        // Reset for two edges, then fixed reset-state values.
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        check("rst_out", {28'd0, bus_hi.out}, 32'd0);
        check("rst_disp", {25'd0, bus_hi.display}, {25'd0, 7'b1111110});
        check("rst_disp_lo", {25'd0, bus_lo.display}, {25'd0, 7'b0000001});

        // Count up across the full range and through the wrap.
        for (int i = 0; i < 17; i++) step(1'b1, 1'b1);

        // Down from reset, then reverse direction.
        step(1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1);
        step(1'b1, 1'b1);

        // Reset mid-count with either direction.
        step(1'b1, 1'b0);
        for (int i = 0; i < 7; i++) step(1'b1, 1'b1);
        step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        step(1'b1, 1'b0);

        // Random direction with occasional reset.
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), ($urandom_range(0, 15) != 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
